// File: rtl/shift_out_driver.sv
// shift_out_driver: serializes DATA_IN MSB-first into a 74HC595 chain (SER/SHCP/STCP/MR_BAR) via START/CLEAR -> BUSY/DONE; define SHIFT_OUT_READBACK_EN to add Q in, READBACK/MISMATCH out
module shift_out_driver #(
  parameter int WIDTH = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             START,
  input  logic             CLEAR,
`ifdef SHIFT_OUT_READBACK_EN
  input  logic             Q,
  output logic [WIDTH-1:0] READBACK,
  output logic             MISMATCH,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             SER,
  output logic             SHCP,
  output logic             STCP,
  output logic             MR_BAR
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LATCH, CLR, FIN} state_t;
  state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic last, ser_n;
  assign last = phase == PW'(CLK_DIV - 1);
  always_comb begin
    state_n = state;
    shadow_n = shadow;
    bit_n = bit_idx;
    case (state)
      IDLE:
        if (CLEAR) state_n = CLR;
        else if (START) begin
          state_n = SH_LO;
          shadow_n = DATA_IN;
          bit_n = BW'(WIDTH - 1);
        end
      SH_LO: if (last) state_n = SH_HI;
      SH_HI:
        if (last) begin
          state_n = (bit_idx == '0) ? LATCH : SH_LO;
          bit_n = (bit_idx == '0) ? bit_idx : bit_idx - BW'(1);
        end
      LATCH, CLR: if (last) state_n = FIN;
      default: state_n = IDLE;
    endcase
    phase_n = (state_n != state || state == IDLE) ? '0 : phase + PW'(1);
    ser_n = (state_n == SH_LO) ? shadow_n[bit_n] : SER;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      phase <= '0;
      bit_idx <= '0;
      shadow <= '0;
      SER <= 1'b0;
      SHCP <= 1'b0;
      STCP <= 1'b0;
      MR_BAR <= 1'b1;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      bit_idx <= bit_n;
      shadow <= shadow_n;
      SER <= ser_n;
      SHCP <= state_n == SH_HI;
      STCP <= state_n == LATCH;
      MR_BAR <= state_n != CLR;
      BUSY <= state_n inside {SH_LO, SH_HI, LATCH, CLR};
      DONE <= state_n == FIN;
    end
`ifdef SHIFT_OUT_READBACK_EN
  logic [WIDTH-1:0] sent;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      READBACK <= '0;
      MISMATCH <= 1'b0;
      sent <= '0;
    end else begin
      if (state == SH_LO && last) READBACK <= {READBACK[WIDTH-2:0], Q};
      if (state == LATCH && last) begin
        MISMATCH <= READBACK != sent;
        sent <= shadow;
      end
      if (state == CLR && last) sent <= '0;
    end
`endif
endmodule

// File: tb/tb_shift_out_driver.sv
// tb_shift_out_driver: directed and random transfers checked against a 74HC595 chain model
module tb_shift_out_driver;
  localparam int W = 8;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic busy, done, ser, shcp, stcp, mr_bar;
  logic [1:0] data2 = '0;
  logic start2 = 1'b0;
  logic busy2, done2, ser2, shcp2, stcp2, mr2;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int lat = 0;
  int shcp_rises = 0, stcp_rises = 0, stcp_hi = 0, mr_lo = 0, dones = 0;
  int s_shcp = 0, s_stcp = 0, s_hi = 0, s_mr = 0, s_done = 0;
  logic shcp_q = 1'b0;
  logic stcp_q = 1'b0;
  logic [W-1:0] chain = '0;
  logic [W-1:0] latched = '0;
  logic flip = 1'b0;
`ifdef SHIFT_OUT_READBACK_EN
  logic q;
  logic [W-1:0] readback;
  logic mismatch;
  logic [1:0] rb2;
  logic mm2;
  logic [W-1:0] prev_sent = '0;
  logic [W-1:0] corrupt_mask = '0;
  assign q = chain[W-1] ^ flip;
`endif
  shift_out_driver #(.WIDTH(W), .CLK_DIV(D)) dut (
    .CLK(clk), .RST(rst), .DATA_IN(data_in), .START(start), .CLEAR(clear),
`ifdef SHIFT_OUT_READBACK_EN
    .Q(q), .READBACK(readback), .MISMATCH(mismatch),
`endif
    .BUSY(busy), .DONE(done), .SER(ser), .SHCP(shcp), .STCP(stcp), .MR_BAR(mr_bar)
  );
  shift_out_driver #(.WIDTH(2), .CLK_DIV(1)) dut2 (
    .CLK(clk), .RST(rst), .DATA_IN(data2), .START(start2), .CLEAR(1'b0),
`ifdef SHIFT_OUT_READBACK_EN
    .Q(1'b0), .READBACK(rb2), .MISMATCH(mm2),
`endif
    .BUSY(busy2), .DONE(done2), .SER(ser2), .SHCP(shcp2), .STCP(stcp2), .MR_BAR(mr2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (shcp && !shcp_q) begin
      shcp_rises++;
      chain = {chain[W-2:0], ser};
    end
    if (stcp && !stcp_q) begin
      stcp_rises++;
      latched = chain;
    end
    if (stcp) stcp_hi++;
    if (!mr_bar) begin
      mr_lo++;
      chain = '0;
    end
    if (done) dones++;
    shcp_q = shcp;
    stcp_q = stcp;
  end
  function automatic int exp_lat(input int w, input int d);
    return 1 + 2 * d * w + d;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    s_shcp = shcp_rises;
    s_stcp = stcp_rises;
    s_hi = stcp_hi;
    s_mr = mr_lo;
    s_done = dones;
  endtask
  task automatic xfer(input logic [W-1:0] d, input bit clr, input int p1, input int p2, input int fa);
    int c;
    @(negedge clk);
    snap();
    data_in = d;
    start = 1'b1;
    clear = clr;
    c = cyc;
    lat = -1;
    for (int k = 0; k < 400 && lat < 0; k++) begin
      @(negedge clk);
      clear = 1'b0;
      start = (cyc - c == p1) || (cyc - c == p2);
      if (start) data_in = '1;
      flip = cyc - c == fa;
      if (done) lat = cyc - c;
    end
    start = 1'b0;
    flip = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask
  task automatic chk_xfer(input string tag, input logic [W-1:0] d);
    chk({tag, "_lat"}, lat, exp_lat(W, D));
    chk({tag, "_word"}, latched, d);
    chk({tag, "_shcp"}, shcp_rises - s_shcp, W);
    chk({tag, "_stcp"}, stcp_rises - s_stcp, 1);
    chk({tag, "_stcpw"}, stcp_hi - s_hi, D);
    chk({tag, "_done"}, dones - s_done, 1);
`ifdef SHIFT_OUT_READBACK_EN
    chk({tag, "_rb"}, readback, prev_sent ^ corrupt_mask);
    chk({tag, "_mm"}, mismatch, |corrupt_mask);
    prev_sent = d;
    corrupt_mask = '0;
`endif
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ser"}, ser, 0);
    chk({tag, "_shcp"}, shcp, 0);
    chk({tag, "_stcp"}, stcp, 0);
    chk({tag, "_mr"}, mr_bar, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef SHIFT_OUT_READBACK_EN
    chk({tag, "_rb"}, readback, 0);
    chk({tag, "_mm"}, mismatch, 0);
`endif
  endtask
  initial begin
    logic [W-1:0] rd;
    logic [7:0] pat, exp_pat, st_pat, exp_st;
    logic [1:0] sw;
    int c, dpos;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    xfer(8'hA5, 1'b0, -1, -1, -1);
    chk_xfer("basic", 8'hA5);
    xfer(8'hA5, 1'b0, 5, 20, -1);
    chk_xfer("busy", 8'hA5);
    xfer(8'h3C, 1'b0, -1, -1, -1);
    chk_xfer("second", 8'h3C);
`ifdef SHIFT_OUT_READBACK_EN
    corrupt_mask = 8'h80;
    xfer(8'h5A, 1'b0, -1, -1, 2);
    chk_xfer("corrupt", 8'h5A);
`endif
    for (int i = 0; i < 5; i++) begin
      rd = W'($urandom);
      xfer(rd, 1'b0, -1, -1, -1);
      chk_xfer($sformatf("rand%0d", i), rd);
    end
    xfer(8'hC3, 1'b1, -1, -1, -1);
    chk("clr_lat", lat, 1 + D);
    chk("clr_mr", mr_lo - s_mr, D);
    chk("clr_shcp", shcp_rises - s_shcp, 0);
    chk("clr_stcp", stcp_rises - s_stcp, 0);
    chk("clr_done", dones - s_done, 1);
    chk("clr_chain", chain, 0);
`ifdef SHIFT_OUT_READBACK_EN
    prev_sent = '0;
`endif
    @(negedge clk);
    snap();
    data_in = 8'hA5;
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - c < 10) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_stcp", stcp_rises - s_stcp, 0);
    chk("midrst_done", dones - s_done, 0);
    xfer(8'h00, 1'b1, -1, -1, -1);
    chk("reclr_lat", lat, 1 + D);
    xfer(8'h96, 1'b0, -1, -1, -1);
    chk_xfer("recover", 8'h96);
    @(negedge clk);
    data2 = 2'b10;
    start2 = 1'b1;
    pat = '0;
    st_pat = '0;
    sw = '0;
    dpos = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      pat[k-1] = shcp2;
      st_pat[k-1] = stcp2;
      if (shcp2) sw = {sw[0], ser2};
      if (done2 && dpos < 0) dpos = k;
    end
    exp_pat = '0;
    exp_st = '0;
    for (int k = 1; k <= 4; k++) exp_pat[k-1] = (k % 2) == 0;
    exp_st[4] = 1'b1;
    chk("div_shcp", pat, exp_pat);
    chk("div_stcp", st_pat, exp_st);
    chk("div_ser", sw, 2'b10);
    chk("div_done", dpos, exp_lat(2, 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
